// File: rtl/fifo_word_unpacker_if.sv
// Purpose: bundles the FIFO read port and the narrow output stream of the word unpacker.
// Latency: none, this is wiring only.
// Backpressure: m_ready from the stream sink; fifo_rd_en is the pop strobe back to the FIFO.
// Ports: fifo_rd_data/fifo_empty/fifo_rd_en (FWFT FIFO read side),
//        m_data/m_valid/m_last/m_ready (valid/ready sub-word stream).
// master = the unpacker, slave = the FIFO and sink environment around it.
interface fifo_word_unpacker_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  fifo_rd_data;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;

    modport master (
        input  fifo_rd_data,
        input  fifo_empty,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output fifo_rd_data,
        output fifo_empty,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Purpose: pops wide FIFO words and serialises each into RATIO sub-words, LSB sub-word first.
// Latency: first sub-word valid the cycle after the pop; sustained one sub-word per cycle.
// Backpressure: m_ready stalls the held sub-word; the next pop only happens as the last beat leaves.
// Ports: clk/rst_n (FIFO read clock, async active-low reset), enable (permit pops),
//        clear (drop held word), bus (FIFO read side + output stream),
//        word_count/starve_count (wrapping status counters).
module fifo_word_unpacker #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    fifo_word_unpacker_if.master bus,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] starve_count
);

    // IN_WIDTH is expected to be an integer multiple of OUT_WIDTH.
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int SEL_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 state;
    logic [IN_WIDTH-1:0]    word_buf;
    logic [SEL_WIDTH-1:0]   sel;

    logic                   buf_valid;
    logic                   at_last;
    logic                   beat;
    logic                   pop;
    logic [OUT_WIDTH-1:0]   sub_word [RATIO];

    // Slice the held word into sub-words so the output mux is a plain array index.
    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign sub_word[g] = word_buf[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign buf_valid = (state == ST_DRAIN);
    assign at_last   = (sel == SEL_LAST);

    assign bus.m_valid = buf_valid;
    assign bus.m_data  = sub_word[sel];
    assign bus.m_last  = buf_valid & at_last;

    assign beat = buf_valid & bus.m_ready;

    // Pop when the buffer is empty or its last beat is leaving this cycle, so
    // the next word lands with no bubble. rst_n gates the strobe so nothing is
    // popped while the block sits in reset.
    assign pop = rst_n & enable & ~clear & ~bus.fifo_empty
               & (~buf_valid | (bus.m_ready & bus.m_last));

    assign bus.fifo_rd_en = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            word_buf     <= '0;
            sel          <= '0;
            word_count   <= '0;
            starve_count <= '0;
        end else begin
            // Counters run independently of clear and wrap naturally.
            if (enable && bus.m_ready && !buf_valid) begin
                starve_count <= starve_count + CNT_WIDTH'(1);
            end
            if (pop) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end

            if (clear) begin
                state <= ST_EMPTY;
                sel   <= '0;
            end else if (pop) begin
                // Covers both the empty-buffer load and the reload on a last beat.
                word_buf <= bus.fifo_rd_data;
                state    <= ST_DRAIN;
                sel      <= '0;
            end else if (beat) begin
                if (at_last) begin
                    state <= ST_EMPTY;
                    sel   <= '0;
                end else begin
                    sel <= sel + SEL_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
module tb_fifo_word_unpacker;

    localparam int IW = 64;
    localparam int OW = 16;
    localparam int CW = 32;
    localparam int R  = IW / OW;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          enable = 1'b0;
    logic          clear  = 1'b0;
    logic [CW-1:0] word_count;
    logic [CW-1:0] starve_count;

    fifo_word_unpacker_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fifo_word_unpacker #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
        .bus          (bus),
        .word_count   (word_count),
        .starve_count (starve_count)
    );

    always #5 clk = ~clk;

    // First-word fall-through FIFO model.
    logic [IW-1:0] fifo_mem [64];
    int            wr_ptr   = 0;
    int            rd_ptr   = 0;
    bit            pop_flag = 1'b0;

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = fifo_mem[rd_ptr % 64];

    always @(posedge clk) begin
        if (pop_flag) rd_ptr <= rd_ptr + 1;
    end

    // Scoreboard entries are {last, data}.
    logic [OW:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    // Monitor: sample on the falling edge, inputs only change just after rising edges.
    always @(negedge clk) begin
        logic [OW:0] e;
        pop_flag = bus.fifo_rd_en;
        if (bus.fifo_rd_en) begin
            n_pops++;
            n_tests++;
            if (bus.fifo_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL underflow: fifo_rd_en=1 with fifo_empty=%b, required fifo_empty=0", bus.fifo_empty);
            end
        end
        if (rst_n && bus.m_valid && bus.m_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", bus.m_data, bus.m_last);
            end else begin
                e = exp_q.pop_front();
                if ({bus.m_last, bus.m_data} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                             bus.m_data, bus.m_last, e[OW-1:0], e[OW]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr++;
        for (int i = 0; i < R; i++) begin
            exp_q.push_back({(i == R - 1) ? 1'b1 : 1'b0, w[i*OW +: OW]});
        end
    endtask

    // Drop the remaining expected beats of a word the DUT discarded.
    task automatic flush_word;
        logic [OW:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[OW]) break;
        end
    endtask

    task automatic drain(input int bound, output bit ok);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset;
        bus.m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests += 6;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
        if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b, required 0", bus.m_last); end
        if (bus.m_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data: got %h, required 0000", bus.m_data); end
        if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, required 0", bus.fifo_rd_en); end
        if (word_count !== 32'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d, required 0", word_count); end
        if (starve_count !== 32'd0) begin n_fail++; $display("FAIL reset_starve_count: got %0d, required 0", starve_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word;
        int            p0;
        logic [CW-1:0] wc0;
        bit            ok;
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        wc0 = word_count;
        p0  = n_pops;
        push_word(64'h4444_3333_2222_1111);
        #1;
        n_tests++;
        if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_pop_now: got %b, required 1", bus.fifo_rd_en); end
        tick();
        n_tests += 2;
        if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: m_valid=%b, required 1", bus.m_valid); end
        if (bus.m_data !== 16'h1111) begin n_fail++; $display("FAIL single_first: got %h, required 1111", bus.m_data); end
        drain(10, ok);
        n_tests += 4;
        if (!ok) begin n_fail++; $display("FAIL single_drain: %0d beats left, required 0", exp_q.size()); end
        if (n_pops - p0 != 1) begin n_fail++; $display("FAIL single_pops: got %0d, required 1", n_pops - p0); end
        if (word_count !== wc0 + 32'd1) begin n_fail++; $display("FAIL single_word_count: got %0d, required %0d", word_count, wc0 + 32'd1); end
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: m_valid=%b, required 0", bus.m_valid); end
    endtask

    task automatic test_back_to_back;
        logic [13:0]   pop_bits;
        logic [13:0]   vld_bits;
        logic [CW-1:0] wc0;
        wc0 = word_count;
        bus.m_ready = 1'b1;
        push_word(64'h1A03_1A02_1A01_1A00);
        push_word(64'h2B03_2B02_2B01_2B00);
        push_word(64'h3C03_3C02_3C01_3C00);
        for (int c = 0; c < 14; c++) begin
            #1;
            pop_bits[c] = bus.fifo_rd_en;
            vld_bits[c] = bus.m_valid;
            @(posedge clk);
        end
        #1;
        n_tests += 4;
        if (pop_bits !== 14'h0111) begin n_fail++; $display("FAIL b2b_pop_timing: got %b, required %b", pop_bits, 14'h0111); end
        if (vld_bits !== 14'h1FFE) begin n_fail++; $display("FAIL b2b_no_gap: got %b, required %b", vld_bits, 14'h1FFE); end
        if (word_count !== wc0 + 32'd3) begin n_fail++; $display("FAIL b2b_word_count: got %0d, required %0d", word_count, wc0 + 32'd3); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        bit            prev_stall = 1'b0;
        logic [OW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        int            p0;
        int            c = 0;
        p0 = n_pops;
        push_word(64'hD004_D003_D002_D001);
        push_word(64'hE004_E003_E002_E001);
        while (exp_q.size() > 0 && c < 40) begin
            bus.m_ready = (c % 2 == 0);
            #1;
            if (prev_stall) begin
                n_tests++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL bp_stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
                end
            end
            if (bus.m_valid) begin
                n_tests++;
                if (bus.fifo_rd_en && !(bus.m_ready && bus.m_last)) begin
                    n_fail++;
                    $display("FAIL bp_early_pop: got rd_en=1 with ready=%b last=%b, required rd_en=0", bus.m_ready, bus.m_last);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            tick();
            c++;
        end
        bus.m_ready = 1'b1;
        n_tests += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d beats left, required 0", exp_q.size()); end
        if (n_pops - p0 != 2) begin n_fail++; $display("FAIL bp_pops: got %0d, required 2", n_pops - p0); end
    endtask

    task automatic test_clear;
        logic [CW-1:0] wc0;
        bit            ok;
        bus.m_ready = 1'b1;
        push_word(64'h5504_5503_5502_5501);
        push_word(64'h6604_6603_6602_6601);
        tick();
        tick();
        tick();
        bus.m_ready = 1'b0;
        clear       = 1'b1;
        #1;
        wc0 = word_count;
        n_tests += 2;
        if (bus.m_data !== 16'h5503) begin n_fail++; $display("FAIL clear_position: got %h, required 5503", bus.m_data); end
        if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL clear_no_pop: got %b, required 0", bus.fifo_rd_en); end
        tick();
        clear       = 1'b0;
        bus.m_ready = 1'b1;
        flush_word();
        #1;
        n_tests += 3;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL clear_m_valid: got %b, required 0", bus.m_valid); end
        if (word_count !== wc0) begin n_fail++; $display("FAIL clear_word_count: got %0d, required %0d", word_count, wc0); end
        if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL clear_next_pop: got %b, required 1", bus.fifo_rd_en); end
        drain(10, ok);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL clear_drain: %0d beats left, required 0", exp_q.size()); end
        if (word_count !== wc0 + 32'd1) begin n_fail++; $display("FAIL clear_after_count: got %0d, required %0d", word_count, wc0 + 32'd1); end
    endtask

    task automatic test_starve_enable;
        logic [CW-1:0] sc0;
        logic [CW-1:0] wc1;
        int            hi = 0;
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        sc0 = starve_count;
        for (int i = 0; i < 10; i++) begin
            if (bus.fifo_rd_en !== 1'b0) hi++;
            tick();
        end
        n_tests += 2;
        if (starve_count !== sc0 + 32'd10) begin n_fail++; $display("FAIL starve_count: got %0d, required %0d", starve_count, sc0 + 32'd10); end
        if (hi != 0) begin n_fail++; $display("FAIL starve_no_pop: rd_en high %0d cycles, required 0", hi); end
        enable = 1'b0;
        sc0 = starve_count;
        wc1 = word_count;
        push_word(64'h7704_7703_7702_7701);
        push_word(64'h8804_8803_8802_8801);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.fifo_rd_en !== 1'b0) hi++;
            tick();
        end
        n_tests += 4;
        if (hi != 0) begin n_fail++; $display("FAIL disable_no_pop: rd_en high %0d cycles, required 0", hi); end
        if (starve_count !== sc0) begin n_fail++; $display("FAIL disable_starve_frozen: got %0d, required %0d", starve_count, sc0); end
        if (word_count !== wc1) begin n_fail++; $display("FAIL disable_word_count: got %0d, required %0d", word_count, wc1); end
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL disable_m_valid: got %b, required 0", bus.m_valid); end
    endtask

    task automatic test_reset_midword;
        bit ok;
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_tests += 6;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_m_valid: got %b, required 0", bus.m_valid); end
        if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL mid_reset_m_last: got %b, required 0", bus.m_last); end
        if (bus.m_data !== 16'h0) begin n_fail++; $display("FAIL mid_reset_m_data: got %h, required 0000", bus.m_data); end
        if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rd_en: got %b, required 0", bus.fifo_rd_en); end
        if (word_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_word_count: got %0d, required 0", word_count); end
        if (starve_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_starve: got %0d, required 0", starve_count); end
        flush_word();
        tick();
        tick();
        n_tests++;
        if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL held_reset_rd_en: got %b, required 0", bus.fifo_rd_en); end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL post_reset_pop: got %b, required 1", bus.fifo_rd_en); end
        drain(10, ok);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL post_reset_drain: %0d beats left, required 0", exp_q.size()); end
        if (word_count !== 32'd1) begin n_fail++; $display("FAIL post_reset_word_count: got %0d, required 1", word_count); end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_starve_enable();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
